// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core. It merges the EX redirect, ID load-use, EX busy and MEM
// busy requests into a PC redirect, per-stage stall/flush controls and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              JumpFlagFromEx,
    input  logic [ADDR_W-1:0] JumpAddrFromEx,
    input  logic              LoadUseFromId,
    input  logic              DivBusyFromEx,
    input  logic              MemBusyFromMem,
    output logic              JumpFlagToPc,
    output logic [ADDR_W-1:0] JumpAddrToPc,
    output logic [3:0]        StallOut,
    output logic              FlushIdOut,
    output logic              FlushExOut,
    output logic              FlushMemOut,
    output logic [PERF_W-1:0] StallCntOut
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    // A single-cycle flush is fully covered by the redirect cycle itself.
    localparam state_t POST_REDIRECT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    state_t              r_state;
    logic                r_pend_valid;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [3:0]          r_flush_cnt;
    logic [PERF_W-1:0]   r_stall_cnt;

    state_t              w_state_next;
    logic                w_pend_valid_next;
    logic [ADDR_W-1:0]   w_pend_addr_next;
    logic [3:0]          w_flush_cnt_next;
    logic                w_stall_req;
    logic                w_jump_flag;
    logic [ADDR_W-1:0]   w_jump_addr;
    logic [3:0]          w_stall;
    logic                w_flush_id;
    logic                w_flush_ex;
    logic                w_flush_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_flush_cnt  <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_addr  <= w_pend_addr_next;
            r_flush_cnt  <= w_flush_cnt_next;
            if ((w_stall != 4'b0000) && (r_stall_cnt != {PERF_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pend_valid_next = r_pend_valid;
        w_pend_addr_next  = r_pend_addr;
        w_flush_cnt_next  = r_flush_cnt;
        w_jump_flag       = 1'b0;
        w_jump_addr       = '0;
        w_stall           = 4'b0000;
        w_flush_id        = 1'b0;
        w_flush_ex        = 1'b0;
        w_flush_mem       = 1'b0;
        w_stall_req       = MemBusyFromMem | DivBusyFromEx;

        if (w_stall_req) begin
            if (MemBusyFromMem) begin
                w_stall = 4'b1111;
            end else begin
                w_stall     = 4'b0111;
                w_flush_mem = 1'b1;
            end
            // A stall inside FLUSH freezes the flush countdown; otherwise park the first jump seen.
            if (r_state != ST_FLUSH) begin
                w_state_next = ST_STALL;
                if (JumpFlagFromEx && !r_pend_valid) begin
                    w_pend_valid_next = 1'b1;
                    w_pend_addr_next  = JumpAddrFromEx;
                end
            end
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_flush_id = 1'b1;
                    w_flush_ex = 1'b1;
                    if (r_flush_cnt <= 4'd1) begin
                        w_state_next     = ST_RUN;
                        w_flush_cnt_next = 4'd0;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    if ((r_state == ST_STALL) && r_pend_valid) begin
                        // The EX jump flag still belongs to the parked instruction: ignore it.
                        w_jump_flag       = 1'b1;
                        w_jump_addr       = r_pend_addr;
                        w_flush_id        = 1'b1;
                        w_flush_ex        = 1'b1;
                        w_pend_valid_next = 1'b0;
                        w_flush_cnt_next  = FLUSH_RELOAD;
                        w_state_next      = POST_REDIRECT;
                    end else if (JumpFlagFromEx) begin
                        w_jump_flag      = 1'b1;
                        w_jump_addr      = JumpAddrFromEx;
                        w_flush_id       = 1'b1;
                        w_flush_ex       = 1'b1;
                        w_flush_cnt_next = FLUSH_RELOAD;
                        w_state_next     = POST_REDIRECT;
                    end else begin
                        w_state_next = ST_RUN;
                        if (LoadUseFromId) begin
                            w_stall    = 4'b0011;
                            w_flush_ex = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are forced low for the whole time reset is held, independent of the inputs.
    assign JumpFlagToPc = rst_n & w_jump_flag;
    assign JumpAddrToPc = rst_n ? w_jump_addr : '0;
    assign StallOut     = rst_n ? w_stall : 4'b0000;
    assign FlushIdOut   = rst_n & w_flush_id;
    assign FlushExOut   = rst_n & w_flush_ex;
    assign FlushMemOut  = rst_n & w_flush_mem;
    assign StallCntOut  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance A (1 flush cycle) runs a vector table,
// instance B (3 flush cycles, 2-bit counter) covers flush stretching and counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        jump;
    logic [63:0] jaddr;
    logic        lu;
    logic        div;
    logic        mem;

    logic        jf_a, fid_a, fex_a, fmem_a;
    logic [63:0] ja_a;
    logic [3:0]  stall_a;
    logic [31:0] cnt_a;
    logic        jf_b, fid_b, fex_b, fmem_b;
    logic [63:0] ja_b;
    logic [3:0]  stall_b;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.ADDR_W(64), .FLUSH_CYCLES(1), .PERF_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .JumpFlagFromEx(jump), .JumpAddrFromEx(jaddr), .LoadUseFromId(lu),
        .DivBusyFromEx(div), .MemBusyFromMem(mem),
        .JumpFlagToPc(jf_a), .JumpAddrToPc(ja_a), .StallOut(stall_a),
        .FlushIdOut(fid_a), .FlushExOut(fex_a), .FlushMemOut(fmem_a), .StallCntOut(cnt_a)
    );

    pipe_hazard_ctrl #(.ADDR_W(64), .FLUSH_CYCLES(3), .PERF_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .JumpFlagFromEx(jump), .JumpAddrFromEx(jaddr), .LoadUseFromId(lu),
        .DivBusyFromEx(div), .MemBusyFromMem(mem),
        .JumpFlagToPc(jf_b), .JumpAddrToPc(ja_b), .StallOut(stall_b),
        .FlushIdOut(fid_b), .FlushExOut(fex_b), .FlushMemOut(fmem_b), .StallCntOut(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        jump;
        logic [63:0] addr;
        logic        lu;
        logic        div;
        logic        mem;
        logic        e_jf;
        logic [63:0] e_ja;
        logic [3:0]  e_stall;
        logic        e_fid;
        logic        e_fex;
        logic        e_fmem;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    // Packed view: {jf, ja[63:0], stall[3:0], fid, fex, fmem, cnt[31:0]}
    function automatic logic [103:0] pack(input logic jf, input logic [63:0] ja, input logic [3:0] st,
                                          input logic fi, input logic fe, input logic fm,
                                          input logic [31:0] cn);
        return {jf, ja, st, fi, fe, fm, cn};
    endfunction

    function automatic logic [103:0] act_a();
        return pack(jf_a, ja_a, stall_a, fid_a, fex_a, fmem_a, cnt_a);
    endfunction

    function automatic logic [103:0] act_b();
        return pack(jf_b, ja_b, stall_b, fid_b, fex_b, fmem_b, {30'd0, cnt_b});
    endfunction

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got jf=%0b ja=%h st=%b fid=%0b fex=%0b fmem=%0b cnt=%0d, want jf=%0b ja=%h st=%b fid=%0b fex=%0b fmem=%0b cnt=%0d",
                     name, act[103], act[102:39], act[38:35], act[34], act[33], act[32], act[31:0],
                     exp[103], exp[102:39], exp[38:35], exp[34], exp[33], exp[32], exp[31:0]);
        end else begin
            $display("ok   %s: jf=%0b ja=%h st=%b fid=%0b fex=%0b fmem=%0b cnt=%0d",
                     name, act[103], act[102:39], act[38:35], act[34], act[33], act[32], act[31:0]);
        end
    endtask

    // New inputs go in just after the rising edge; outputs are sampled mid-cycle.
    task automatic drive(input logic j, input logic [63:0] a, input logic l, input logic d, input logic m);
        @(posedge clk);
        #1;
        jump = j; jaddr = a; lu = l; div = d; mem = m;
        #3;
    endtask

    task automatic do_reset();
        jump = 1'b0; jaddr = '0; lu = 1'b0; div = 1'b0; mem = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //          jump addr            lu    div   mem   jf    ja               stall    fid   fex   fmem  cnt
        vecs[0]  = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 64'h8000_0040,  1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0040,   4'b0000, 1'b1, 1'b1, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 64'h0,          1'b1, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0011, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[5]  = '{1'b1, 64'h100,        1'b0, 1'b0, 1'b1, 1'b0, 64'h0,           4'b1111, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[6]  = '{1'b1, 64'h100,        1'b0, 1'b0, 1'b1, 1'b0, 64'h0,           4'b1111, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[7]  = '{1'b1, 64'h200,        1'b0, 1'b0, 1'b1, 1'b0, 64'h0,           4'b1111, 1'b0, 1'b0, 1'b0, 32'd3};
        vecs[8]  = '{1'b1, 64'h100,        1'b0, 1'b0, 1'b0, 1'b1, 64'h100,         4'b0000, 1'b1, 1'b1, 1'b0, 32'd4};
        vecs[9]  = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd4};
        vecs[10] = '{1'b0, 64'h0,          1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd4};
        vecs[11] = '{1'b0, 64'h0,          1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd5};
        vecs[12] = '{1'b0, 64'h0,          1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd6};
        vecs[13] = '{1'b0, 64'h0,          1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd7};
        vecs[14] = '{1'b0, 64'h0,          1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd8};
        vecs[15] = '{1'b0, 64'h0,          1'b0, 1'b1, 1'b1, 1'b0, 64'h0,           4'b1111, 1'b0, 1'b0, 1'b0, 32'd9};
        vecs[16] = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd10};
        vecs[17] = '{1'b0, 64'h0,          1'b1, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd10};
        vecs[18] = '{1'b0, 64'h0,          1'b1, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0011, 1'b0, 1'b1, 1'b0, 32'd11};
        vecs[19] = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd12};
        vecs[20] = '{1'b1, 64'hAAA0,       1'b0, 1'b1, 1'b0, 1'b0, 64'h0,           4'b0111, 1'b0, 1'b0, 1'b1, 32'd12};
        vecs[21] = '{1'b1, 64'hBBB0,       1'b1, 1'b0, 1'b0, 1'b1, 64'hAAA0,        4'b0000, 1'b1, 1'b1, 1'b0, 32'd13};
        vecs[22] = '{1'b0, 64'h0,          1'b0, 1'b0, 1'b0, 1'b0, 64'h0,           4'b0000, 1'b0, 1'b0, 1'b0, 32'd13};

        // Reset: outputs must be quiet even with a bus wait applied.
        rst_n = 1'b0;
        jump = 1'b1; jaddr = 64'h1234; lu = 1'b1; div = 1'b0; mem = 1'b1;
        #12;
        chk("reset_a", act_a(), '0);
        chk("reset_b", act_b(), '0);
        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].jump, vecs[i].addr, vecs[i].lu, vecs[i].div, vecs[i].mem);
            chk($sformatf("vec%0d", i), act_a(),
                pack(vecs[i].e_jf, vecs[i].e_ja, vecs[i].e_stall, vecs[i].e_fid,
                     vecs[i].e_fex, vecs[i].e_fmem, vecs[i].e_cnt));
        end

        // Three-cycle flush interrupted by a bus wait, then counter saturation at 3.
        do_reset();
        drive(1'b1, 64'h4000, 1'b0, 1'b0, 1'b0);
        chk("flush3_redirect", act_b(), pack(1'b1, 64'h4000, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd0));
        drive(1'b1, 64'h4000, 1'b0, 1'b0, 1'b1);
        chk("flush3_memstall", act_b(), pack(1'b0, 64'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 32'd0));
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("flush3_c2", act_b(), pack(1'b0, 64'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd1));
        drive(1'b1, 64'h5000, 1'b1, 1'b0, 1'b0);
        chk("flush3_c3", act_b(), pack(1'b0, 64'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd1));
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("flush3_done", act_b(), pack(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd1));
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("sat_c%0d", k), act_b(),
                pack(1'b0, 64'h0, 4'b1111, 1'b0, 1'b0, 1'b0, (k < 2) ? 32'(k + 1) : 32'd3));
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_hold", act_b(), pack(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd3));

        // Reset while stalled with a parked jump: quiet at once, no redirect afterwards.
        do_reset();
        drive(1'b1, 64'h7770, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_stall", act_a(), pack(1'b0, 64'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 32'd0));
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_stall2", act_a(), pack(1'b0, 64'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 32'd1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", act_a(), '0);
        @(posedge clk);
        #1;
        mem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_after1", act_a(), '0);
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_after2", act_a(), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
